input_conditioner: RTL and testbench

- Front-end stage directly upstream of the counter digit.
- Turns two raw push-button inputs (up, down) into clean single-cycle inc pulses plus a direction level, ready to drive the counter's inc and up_down_sel inputs.
- Per button: 2-flop synchronisation and counter-based debounce.
- Shared press FSM with optional hold-to-auto-repeat and a both-pressed lockout.

---
 rtl/input_conditioner_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/input_conditioner.sv | 127 ++++++++++++
 tb/tb_input_conditioner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and default timing for the push-button input conditioner.
// Exports: state_e (press FSM states), DIR_UP/DIR_DOWN, DEF_* timing defaults.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_REPEAT,
        ST_LOCKOUT
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 20;
    localparam int DEF_REPEAT_PERIOD   = 8;
    localparam int DEF_TMR_W           = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw button.
// Ports: clk, reset (async high), btn_i raw level, deb_o debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TMR_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic deb_o
);

    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             deb_q, deb_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             s_x;

    assign s_x = sync_q[1];

    // Level only moves after DEBOUNCE_CYCLES consecutive differing
    // samples; any agreeing sample restarts the count.
    always_comb begin
        deb_d = deb_q;
        tmr_d = '0;
        if (s_x != deb_q) begin
            if (tmr_q == DEB_LAST) begin
                deb_d = s_x;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            tmr_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            deb_q  <= deb_d;
            tmr_q  <= tmr_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/input_conditioner.sv
// Up/down buttons to counter inc pulses + direction, with auto-repeat.
// Ports: clk, reset, btn_up, btn_down, rep_en in; inc, up_down_sel, busy out.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int TMR_W           = DEF_TMR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic rep_en,
    output logic inc,
    output logic up_down_sel,
    output logic busy
);

    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic             deb_up, deb_down;
    state_e           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic             dir_q;
    logic             inc_q;
    logic             act, oth;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TMR_W           (TMR_W)
    ) u_deb_up (
        .clk   (clk),
        .reset (reset),
        .btn_i (btn_up),
        .deb_o (deb_up)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TMR_W           (TMR_W)
    ) u_deb_down (
        .clk   (clk),
        .reset (reset),
        .btn_i (btn_down),
        .deb_o (deb_down)
    );

    // dir_q is only written together with a pulse, so it also names
    // the button that owns the current press.
    assign act = (dir_q == DIR_DOWN) ? deb_down : deb_up;
    assign oth = (dir_q == DIR_DOWN) ? deb_up : deb_down;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            dir_q   <= DIR_UP;
            inc_q   <= 1'b0;
        end else begin
            inc_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    tmr_q <= '0;
                    if (deb_up && deb_down) begin
                        state_q <= ST_LOCKOUT;
                    end else if (deb_up) begin
                        state_q <= ST_PRESS;
                        dir_q   <= DIR_UP;
                        inc_q   <= 1'b1;
                    end else if (deb_down) begin
                        state_q <= ST_PRESS;
                        dir_q   <= DIR_DOWN;
                        inc_q   <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (!act) begin
                        state_q <= ST_IDLE;
                    end else if (oth) begin
                        state_q <= ST_LOCKOUT;
                    end else if (tmr_q == DLY_LAST) begin
                        // Saturated here; fires as soon as repeat is enabled.
                        if (rep_en) begin
                            state_q <= ST_REPEAT;
                            inc_q   <= 1'b1;
                            tmr_q   <= '0;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!act) begin
                        state_q <= ST_IDLE;
                    end else if (oth) begin
                        state_q <= ST_LOCKOUT;
                    end else if (!rep_en) begin
                        tmr_q <= '0;
                    end else if (tmr_q == PER_LAST) begin
                        inc_q <= 1'b1;
                        tmr_q <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    tmr_q <= '0;
                    if (!deb_up && !deb_down) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmr_q   <= '0;
                end
            endcase
        end
    end

    assign inc         = inc_q;
    assign up_down_sel = dir_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner.
// Expected pulses (cycle, direction) are queued at stimulus time.
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic btn_up, btn_down, rep_en;
    logic inc, up_down_sel, busy;

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t sb[$];

    input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .TMR_W           (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .rep_en      (rep_en),
        .inc         (inc),
        .up_down_sel (up_down_sel),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     tag, got, want, cyc);
        end
    endtask

    task automatic push(input int c, input logic d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: every inc must match the head of the scoreboard,
    // and an expected pulse that never shows up is a miss.
    always @(negedge clk) begin
        if (!reset) begin
            if (inc) begin
                if (sb.size() == 0) begin
                    chk("spurious_inc", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_cyc", cyc, e.cyc);
                    chk("pulse_dir", up_down_sel, e.dir);
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                chk("missed_pulse", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int c;
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        rep_en   = 1'b0;
        wait_cyc(3);
        chk("rst_inc", inc, 0);
        chk("rst_dir", up_down_sel, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        wait_cyc(3);

        // Glitch of 3 cycles is discarded.
        btn_up = 1'b1;
        wait_cyc(3);
        btn_up = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_cyc(1);
            chk("glitch_busy", busy, 0);
        end

        // 4 cycles is long enough for one pulse.
        c = cyc;
        push(c + 7, 1'b0);
        btn_up = 1'b1;
        wait_cyc(4);
        btn_up = 1'b0;
        wait_cyc(20);
        chk("g4_busy", busy, 0);
        chk("g4_sb", sb.size(), 0);

        // Down held 100 cycles without repeat: a single pulse.
        c = cyc;
        push(c + 7, 1'b1);
        btn_down = 1'b1;
        wait_cyc(100);
        btn_down = 1'b0;
        wait_cyc(20);
        chk("dn_dir_hold", up_down_sel, 1);
        chk("dn_busy", busy, 0);
        chk("dn_sb", sb.size(), 0);

        // Up held 60 cycles with repeat.
        rep_en = 1'b1;
        c = cyc;
        push(c + 7, 1'b0);
        push(c + 27, 1'b0);
        for (int k = 0; k < 4; k++) push(c + 35 + 8 * k, 1'b0);
        btn_up = 1'b1;
        wait_cyc(60);
        btn_up = 1'b0;
        wait_cyc(20);
        chk("rep_busy", busy, 0);
        chk("rep_sb", sb.size(), 0);
        rep_en = 1'b0;

        // Both pressed together: lockout until both released.
        btn_up   = 1'b1;
        btn_down = 1'b1;
        wait_cyc(15);
        chk("lk_busy", busy, 1);
        btn_down = 1'b0;
        wait_cyc(15);
        chk("lk_busy2", busy, 1);
        btn_up = 1'b0;
        wait_cyc(15);
        chk("lk_exit", busy, 0);
        c = cyc;
        push(c + 7, 1'b1);
        btn_down = 1'b1;
        wait_cyc(15);
        btn_down = 1'b0;
        wait_cyc(20);
        chk("lk_sb", sb.size(), 0);

        // Other button during repeat: locked out, no more pulses.
        rep_en = 1'b1;
        c = cyc;
        push(c + 7, 1'b0);
        push(c + 27, 1'b0);
        btn_up = 1'b1;
        wait_cyc(26);
        btn_down = 1'b1;
        wait_cyc(40);
        chk("rl_busy", busy, 1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_cyc(20);
        chk("rl_busy2", busy, 0);
        chk("rl_sb", sb.size(), 0);
        rep_en = 1'b0;

        // Reset while inc is high, then a still-held button.
        c = cyc;
        push(c + 7, 1'b1);
        btn_down = 1'b1;
        wait_cyc(7);
        chk("pre_rst_inc", inc, 1);
        #1;
        reset    = 1'b1;
        btn_down = 1'b0;
        btn_up   = 1'b1;
        #1;
        chk("mid_rst_inc", inc, 0);
        chk("mid_rst_dir", up_down_sel, 0);
        chk("mid_rst_busy", busy, 0);
        wait_cyc(3);
        c = cyc;
        push(c + 7, 1'b0);
        reset = 1'b0;
        wait_cyc(15);
        btn_up = 1'b0;
        wait_cyc(20);
        chk("post_rst_busy", busy, 0);
        chk("final_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
